// File: rtl/uno_ctrl_if.sv
// uno_ctrl_if: job request, coefficient-table write and PE control bundle.
// Latency: none, this is wiring only.
// Backpressure: req_valid/req_ready for jobs; cfg writes and PE pins are unflow-controlled.
//
// Signals:
//   req_valid/req_ready/req_op/req_len : job request handshake (requester -> controller)
//   cfg_we/cfg_op/cfg_idx/cfg_data     : coefficient table write port (requester -> controller)
//   pe_op/pe_first_cycle/pe_last_cycle/pe_acc_en/pe_coeff/pe_step_valid : PE control (controller -> PE)
//   busy/done                          : job status (controller -> requester)
// Optional macro UNO_CTRL_ABORT_EN adds abort (requester -> controller) and aborted
// (controller -> requester).
interface uno_ctrl_if #(
    parameter int BW    = 12,
    parameter int LEN_W = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [LEN_W-1:0] req_len;

    logic             cfg_we;
    logic [1:0]       cfg_op;
    logic [2:0]       cfg_idx;
    logic [BW-1:0]    cfg_data;

    logic [1:0]       pe_op;
    logic             pe_first_cycle;
    logic             pe_last_cycle;
    logic             pe_acc_en;
    logic [BW-1:0]    pe_coeff;
    logic             pe_step_valid;

    logic             busy;
    logic             done;

`ifdef UNO_CTRL_ABORT_EN
    logic             abort;
    logic             aborted;

    modport master (
        output req_valid, req_op, req_len,
        output cfg_we, cfg_op, cfg_idx, cfg_data,
        output abort,
        input  req_ready,
        input  pe_op, pe_first_cycle, pe_last_cycle, pe_acc_en, pe_coeff, pe_step_valid,
        input  busy, done, aborted
    );

    modport slave (
        input  req_valid, req_op, req_len,
        input  cfg_we, cfg_op, cfg_idx, cfg_data,
        input  abort,
        output req_ready,
        output pe_op, pe_first_cycle, pe_last_cycle, pe_acc_en, pe_coeff, pe_step_valid,
        output busy, done, aborted
    );
`else
    modport master (
        output req_valid, req_op, req_len,
        output cfg_we, cfg_op, cfg_idx, cfg_data,
        input  req_ready,
        input  pe_op, pe_first_cycle, pe_last_cycle, pe_acc_en, pe_coeff, pe_step_valid,
        input  busy, done
    );

    modport slave (
        input  req_valid, req_op, req_len,
        input  cfg_we, cfg_op, cfg_idx, cfg_data,
        output req_ready,
        output pe_op, pe_first_cycle, pe_last_cycle, pe_acc_en, pe_coeff, pe_step_valid,
        output busy, done
    );
`endif
endinterface

// File: rtl/uno_ctrl.sv
// uno_ctrl: one-job-at-a-time sequencer driving the uno PE control pins (MAC and div/exp/log Horner runs).
// Latency: accept in c0, RUN c1..cN, DRAIN MAC_LAT cycles, done pulse in cN+MAC_LAT+1; all outputs registered.
// Backpressure: req_ready only in IDLE; requests while busy are dropped, not queued. Table writes never stall.
//
// Ports:
//   clk   : clock
//   rst_n : asynchronous reset, active low (clears FSM, outputs and coefficient table)
//   bus   : uno_ctrl_if.slave (job request, coefficient writes, PE control, busy/done)
// Optional macro UNO_CTRL_ABORT_EN: enables bus.abort / bus.aborted. With abort high in
// RUN or DRAIN the job is dropped, PE controls return to zero and aborted pulses once.
module uno_ctrl #(
    parameter int BW      = 12,
    parameter int TERMS   = 4,
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    uno_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0]       OP_MAC     = 2'b00;
    localparam logic [LEN_W-1:0] TERMS_LAST = LEN_W'(TERMS - 1);
    localparam logic [1:0]       DRAIN_LAST = 2'(MAC_LAT - 1);
    localparam logic [3:0]       TERMS_4B   = 4'(TERMS);

    // ------------------------------------------------------------------
    // Sequencing state
    // ------------------------------------------------------------------
    state_t           state, state_nx;
    logic [LEN_W-1:0] k_q, k_nx;          // step index within RUN
    logic [LEN_W-1:0] last_q, last_nx;    // N-1 of the active job
    logic [1:0]       drain_q, drain_nx;  // DRAIN cycle counter
    logic [1:0]       op_q, op_nx;        // latched job op
    logic             abort_hit;

    // Registered outputs and their next values
    logic [1:0]       pe_op_r, pe_op_nx;
    logic             first_r, first_nx;
    logic             last_r, last_flag_nx;
    logic             acc_r, acc_nx;
    logic [BW-1:0]    coeff_r, coeff_nx;
    logic             step_r, step_nx;
    logic             busy_r, busy_nx;
    logic             done_r, done_nx;

    // ------------------------------------------------------------------
    // Coefficient table. Storage is 4 x 8 so the 3-bit index always
    // addresses a real entry; entries at or above TERMS are never written
    // and stay at their reset value.
    // ------------------------------------------------------------------
    logic [BW-1:0] tbl [0:3][0:7];
    logic          cfg_ok;
    logic [BW-1:0] tbl_rd;
    logic          cfg_bypass;

    assign cfg_ok = bus.cfg_we && ({1'b0, bus.cfg_idx} < TERMS_4B);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 4; r++) begin
                for (int i = 0; i < 8; i++) begin
                    tbl[r][i] <= '0;
                end
            end
        end else if (cfg_ok) begin
            tbl[bus.cfg_op][bus.cfg_idx] <= bus.cfg_data;
        end
    end

`ifdef UNO_CTRL_ABORT_EN
    logic aborted_r;

    assign abort_hit = bus.abort && ((state == S_RUN) || (state == S_DRAIN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aborted_r <= 1'b0;
        end else begin
            aborted_r <= abort_hit;
        end
    end

    assign bus.aborted = aborted_r;
`else
    assign abort_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            k_q     <= '0;
            last_q  <= '0;
            drain_q <= '0;
            op_q    <= OP_MAC;
        end else begin
            state   <= state_nx;
            k_q     <= k_nx;
            last_q  <= last_nx;
            drain_q <= drain_nx;
            op_q    <= op_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        k_nx     = k_q;
        last_nx  = last_q;
        drain_nx = drain_q;
        op_nx    = op_q;

        case (state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    op_nx    = bus.req_op;
                    k_nx     = '0;
                    state_nx = S_RUN;
                    if (bus.req_op == OP_MAC) begin
                        // A zero-length MAC job still runs one step.
                        last_nx = (bus.req_len == '0) ? '0 : (bus.req_len - LEN_W'(1));
                    end else begin
                        last_nx = TERMS_LAST;
                    end
                end
            end
            S_RUN: begin
                if (k_q == last_q) begin
                    drain_nx = '0;
                    state_nx = S_DRAIN;
                end else begin
                    k_nx = k_q + LEN_W'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_nx = S_DONE;
                end else begin
                    drain_nx = drain_q + 2'd1;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        if (abort_hit) begin
            state_nx = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Next outputs, decoded from the next state so every pin can be a flop.
    // The coefficient for step k_nx is read one cycle early; a write landing
    // on that same entry at this edge is forwarded so it is seen immediately.
    // ------------------------------------------------------------------
    assign tbl_rd     = tbl[op_nx][k_nx[2:0]];
    assign cfg_bypass = cfg_ok && (bus.cfg_op == op_nx) &&
                        ({{(LEN_W-3){1'b0}}, bus.cfg_idx} == k_nx);

    always_comb begin
        pe_op_nx     = 2'b00;
        first_nx     = 1'b0;
        last_flag_nx = 1'b0;
        acc_nx       = 1'b0;
        coeff_nx     = '0;
        step_nx      = 1'b0;
        busy_nx      = 1'b0;
        done_nx      = 1'b0;

        if (state_nx != S_IDLE) begin
            pe_op_nx = op_nx;
            busy_nx  = 1'b1;
        end

        if (state_nx == S_RUN) begin
            step_nx      = 1'b1;
            first_nx     = (k_nx == '0);
            last_flag_nx = (k_nx == last_nx);
            if (op_nx == OP_MAC) begin
                acc_nx = (k_nx != '0);
            end else begin
                coeff_nx = cfg_bypass ? bus.cfg_data : tbl_rd;
            end
        end

        if (state_nx == S_DONE) begin
            done_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_op_r <= 2'b00;
            first_r <= 1'b0;
            last_r  <= 1'b0;
            acc_r   <= 1'b0;
            coeff_r <= '0;
            step_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            pe_op_r <= pe_op_nx;
            first_r <= first_nx;
            last_r  <= last_flag_nx;
            acc_r   <= acc_nx;
            coeff_r <= coeff_nx;
            step_r  <= step_nx;
            busy_r  <= busy_nx;
            done_r  <= done_nx;
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign bus.req_ready      = (state == S_IDLE);
    assign bus.pe_op          = pe_op_r;
    assign bus.pe_first_cycle = first_r;
    assign bus.pe_last_cycle  = last_r;
    assign bus.pe_acc_en      = acc_r;
    assign bus.pe_coeff       = coeff_r;
    assign bus.pe_step_valid  = step_r;
    assign bus.busy           = busy_r;
    assign bus.done           = done_r;

endmodule

// File: tb/tb_uno_ctrl.sv
// tb_uno_ctrl: randomized self-checking bench for uno_ctrl.
// Latency: expectations are derived per job from cycle numbering (accept c0, RUN c1..cN, DRAIN, DONE).
// Backpressure: requester holds req_valid; the reference predicts when req_ready returns.
module tb_uno_ctrl;
    localparam int BW    = 12;
    localparam int TERMS = 4;
    localparam int LEN_W = 8;
    localparam int LAT   = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uno_ctrl_if #(.BW(BW), .LEN_W(LEN_W)) bus ();

    uno_ctrl #(.BW(BW), .TERMS(TERMS), .LEN_W(LEN_W), .MAC_LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Reference coefficient table: 4 ops x TERMS entries.
    logic [BW-1:0] model [4][TERMS];

    function automatic logic [20:0] obs();
        return {bus.req_ready, bus.pe_op, bus.pe_first_cycle, bus.pe_last_cycle, bus.pe_acc_en,
                bus.pe_coeff, bus.pe_step_valid, bus.busy, bus.done};
    endfunction

    function automatic logic [20:0] mk(input logic rdy, input logic [1:0] op, input logic f,
                                       input logic l, input logic a, input logic [BW-1:0] c,
                                       input logic s, input logic b, input logic d);
        return {rdy, op, f, l, a, c, s, b, d};
    endfunction

    function automatic int job_len(input logic [1:0] op, input int len);
        if (op != 2'b00) return TERMS;
        return (len == 0) ? 1 : len;
    endfunction

    function automatic void model_write(input logic [1:0] op, input int idx, input logic [BW-1:0] d);
        if (idx < TERMS) model[op][idx] = d;
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < TERMS; i++)
                model[r][i] = '0;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] op, input logic [2:0] idx, input logic [BW-1:0] d);
        bus.cfg_we   = 1'b1;
        bus.cfg_op   = op;
        bus.cfg_idx  = idx;
        bus.cfg_data = d;
        next_cycle();
        bus.cfg_we = 1'b0;
        model_write(op, int'(idx), d);
    endtask

    task automatic wait_idle(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk_cnt++;
        if (ok !== 1'b1) $display("FAIL %s idle timeout: req_ready=%b required 1", name, bus.req_ready);
        else pass_cnt++;
        next_cycle();
    endtask

    // Runs one job from an idle DUT and checks every cycle from accept through
    // the first idle cycle. Optionally issues one table write during step wr_k.
    task automatic run_job(input logic [1:0] op, input int len, input int wr_k,
                           input logic [1:0] wr_op, input logic [2:0] wr_idx,
                           input logic [BW-1:0] wr_data, input string name);
        int n, k;
        logic do_wr;
        logic [20:0] e, a;
        n = job_len(op, len);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_len   = LEN_W'(len);
        @(negedge clk);
        chk_cnt++;
        if (bus.req_ready !== 1'b1) $display("FAIL %s accept: req_ready=%b required 1", name, bus.req_ready);
        else pass_cnt++;
        next_cycle();
        for (int t = 1; t <= n + LAT + 2; t++) begin
            // Requests while busy must be ignored; keep it low once IDLE is due.
            bus.req_valid = (t <= n + LAT + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.req_op    = 2'($urandom);
            bus.req_len   = LEN_W'($urandom);
            k = t - 1;
            if (t <= n) begin
                if (op == 2'b00) e = mk(1'b0, op, k == 0, k == n - 1, k != 0, '0, 1'b1, 1'b1, 1'b0);
                else             e = mk(1'b0, op, k == 0, k == n - 1, 1'b0, model[op][k], 1'b1, 1'b1, 1'b0);
            end else if (t <= n + LAT) begin
                e = mk(1'b0, op, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
            end else if (t == n + LAT + 1) begin
                e = mk(1'b0, op, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
            end else begin
                e = mk(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
            end
            do_wr = (k == wr_k) && (t <= n);
            if (do_wr) begin
                bus.cfg_we   = 1'b1;
                bus.cfg_op   = wr_op;
                bus.cfg_idx  = wr_idx;
                bus.cfg_data = wr_data;
            end
            @(negedge clk);
            a = obs();
            chk_cnt++;
            if (a !== e) $display("FAIL %s c%0d: got=%h required=%h", name, t, a, e);
            else pass_cnt++;
            if (do_wr) model_write(wr_op, int'(wr_idx), wr_data);
            next_cycle();
            bus.cfg_we = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [20:0] e;
        e = mk(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        chk_cnt++;
        if (obs() !== e) $display("FAIL reset_state: got=%h required=%h", obs(), e);
        else pass_cnt++;
        #20;
        next_cycle();
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        chk_cnt++;
        if (obs() !== e) $display("FAIL post_reset_idle: got=%h required=%h", obs(), e);
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_mac();
        run_job(2'b00, 4, -1, 2'b00, 3'd0, '0, "mac_len4");
        for (int i = 0; i < 3; i++) run_job(2'b00, $urandom_range(2, 9), -1, 2'b00, 3'd0, '0, "mac_rand");
    endtask

    task automatic test_exp();
        cfg_write(2'b10, 3'd0, 12'h100);
        cfg_write(2'b10, 3'd1, 12'h080);
        cfg_write(2'b10, 3'd2, 12'h02A);
        cfg_write(2'b10, 3'd3, 12'h00B);
        run_job(2'b10, 0, -1, 2'b00, 3'd0, '0, "exp_spec");
        // Index beyond TERMS must leave the row untouched.
        cfg_write(2'b10, 3'd5, 12'hFFF);
        cfg_write(2'b10, 3'd4, 12'hEEE);
        run_job(2'b10, 0, -1, 2'b00, 3'd0, '0, "exp_idx_oob");
    endtask

    task automatic test_len_boundary();
        run_job(2'b00, 0, -1, 2'b00, 3'd0, '0, "len0");
        run_job(2'b00, 1, -1, 2'b00, 3'd0, '0, "len1");
        run_job(2'b00, 255, -1, 2'b00, 3'd0, '0, "len255");
    endtask

    task automatic test_table_race();
        for (int i = 0; i < TERMS; i++) cfg_write(2'b11, 3'(i), 12'($urandom));
        run_job(2'b11, 0, 1, 2'b11, 3'd2, 12'h0AA, "log_race");
        run_job(2'b01, 0, 0, 2'b01, 3'd1, 12'($urandom), "div_race_next");
        run_job(2'b01, 0, 2, 2'b01, 3'd2, 12'($urandom), "div_write_cur");
    endtask

    task automatic test_random();
        logic [1:0] op;
        int len, n;
        for (int r = 1; r < 4; r++)
            for (int i = 0; i < TERMS; i++) cfg_write(2'(r), 3'(i), 12'($urandom));
        for (int j = 0; j < 12; j++) begin
            op  = 2'($urandom);
            len = $urandom_range(0, 12);
            n   = job_len(op, len);
            run_job(op, len, $urandom_range(0, n), 2'($urandom), 3'($urandom), 12'($urandom), "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] ops [6];
        int idx, next_exp, accepts;
        logic exp_rdy;
        ops = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b11};
        idx = 0;
        accepts = 0;
        next_exp = 0;
        bus.req_valid = 1'b1;
        bus.req_len   = LEN_W'(3);
        bus.req_op    = ops[0];
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            exp_rdy = (cyc == next_exp);
            chk_cnt++;
            if (bus.req_ready !== exp_rdy)
                $display("FAIL b2b_ready cyc%0d: got=%b required=%b", cyc, bus.req_ready, exp_rdy);
            else pass_cnt++;
            if (bus.req_ready === 1'b1) begin
                accepts++;
                next_exp = cyc + job_len(ops[idx], 3) + LAT + 2;
            end
            next_cycle();
            if (bus.req_ready === 1'b0 && cyc + 1 != next_exp && accepts > 0 && bus.busy === 1'b1)
                idx = accepts % 6;
            bus.req_op = ops[idx];
        end
        bus.req_valid = 1'b0;
        chk_cnt++;
        if (accepts < 8) $display("FAIL b2b_accepts: got=%0d required>=8", accepts);
        else pass_cnt++;
        wait_idle("b2b");
    endtask

    task automatic test_reset_mid();
        logic [20:0] e;
        e = mk(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b10;
        next_cycle();
        bus.req_valid = 1'b0;
        next_cycle();
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (obs() !== e) $display("FAIL reset_mid: got=%h required=%h", obs(), e);
        else pass_cnt++;
        next_cycle();
        rst_n = 1'b1;
        model_clear();
        run_job(2'b10, 0, -1, 2'b00, 3'd0, '0, "exp_after_reset");
    endtask

`ifdef UNO_CTRL_ABORT_EN
    task automatic test_abort();
        logic [20:0] e;
        e = mk(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b00;
        bus.req_len   = LEN_W'(4);
        next_cycle();
        bus.req_valid = 1'b0;
        next_cycle();
        next_cycle();
        bus.abort = 1'b1;
        next_cycle();
        bus.abort = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if ({obs(), bus.aborted} !== {e, 1'b1}) $display("FAIL abort_c4: got=%h required=%h", {obs(), bus.aborted}, {e, 1'b1});
        else pass_cnt++;
        next_cycle();
        @(negedge clk);
        chk_cnt++;
        if ({bus.aborted, bus.done} !== 2'b00) $display("FAIL abort_c5: got=%b required=00", {bus.aborted, bus.done});
        else pass_cnt++;
        next_cycle();
        // Abort in DONE is ignored.
        bus.req_valid = 1'b1;
        bus.req_len   = LEN_W'(1);
        next_cycle();
        bus.req_valid = 1'b0;
        next_cycle();
        next_cycle();
        bus.abort = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if (bus.done !== 1'b1) $display("FAIL abort_done_c3: done=%b required 1", bus.done);
        else pass_cnt++;
        next_cycle();
        bus.abort = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if ({bus.req_ready, bus.aborted} !== 2'b10) $display("FAIL abort_done_c4: got=%b required=10", {bus.req_ready, bus.aborted});
        else pass_cnt++;
        next_cycle();
    endtask
`endif

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_len   = '0;
        bus.cfg_we    = 1'b0;
        bus.cfg_op    = 2'b00;
        bus.cfg_idx   = 3'd0;
        bus.cfg_data  = '0;
`ifdef UNO_CTRL_ABORT_EN
        bus.abort     = 1'b0;
`endif
        model_clear();
        test_reset();
        test_mac();
        test_exp();
        test_len_boundary();
        test_table_race();
        test_random();
        test_back_to_back();
        test_reset_mid();
`ifdef UNO_CTRL_ABORT_EN
        test_abort();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end
endmodule
